// File: rtl/sram_link_host_pkg.sv
// sram_link_host_pkg: op codes, command byte layout and FSM states shared by both ends of the SRAM/SoC byte link
package sram_link_host_pkg;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_SOC_START = 2'd2, OP_SOC_STOP = 2'd3} op_t;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;
  localparam int CMD_RD_BIT = 5;
  localparam int CMD_SOC_BIT = 6;
  localparam int CMD_RST_BIT = 7;
  localparam int CMD_ADDR_W = 5;
  localparam int WORD_BYTES = 4;
  function automatic logic [7:0] cmd_byte(op_t op, logic [CMD_ADDR_W-1:0] addr);
    logic [7:0] b;
    b = '0;
    b[CMD_ADDR_W-1:0] = (op == OP_READ || op == OP_WRITE) ? addr : '0;
    b[CMD_RD_BIT] = op == OP_READ;
    b[CMD_SOC_BIT] = op == OP_SOC_START;
    b[CMD_RST_BIT] = op == OP_SOC_STOP;
    return b;
  endfunction
endpackage

// File: rtl/link_timeout_counter.sv
// link_timeout_counter: counts enabled idle cycles; expired flags the cycle whose increment would reach TIMEOUT_CYCLES
module link_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  assign expired = en && cnt == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sram_link_host.sv
// sram_link_host: serializes word requests into link bytes and reassembles 4-byte read responses
module sram_link_host
  import sram_link_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        soc_running,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_drop
);
  state_t state, state_n;
  op_t op;
  logic [4:0] addr;
  logic [31:0] wdata, rdata;
  logic [1:0] cnt;
  logic err, run, live, expired;
  logic tx_fire, rx_fire, req_fire, bad_soc;
  // live keeps the request side closed until the first edge after reset releases
  assign req_ready = live && state == IDLE;
  assign rx_ready = live && (state == IDLE || state == RDATA);
  assign tx_valid = state == CMD || state == WDATA;
  assign tx_data = state == CMD ? cmd_byte(op, addr) : state == WDATA ? wdata[{cnt, 3'b000} +: 8] : '0;
  assign tx_fire = tx_valid && tx_ready;
  assign rx_fire = rx_valid && rx_ready;
  assign req_fire = req_valid && req_ready;
  assign rx_drop = state == IDLE && rx_fire;
  assign bad_soc = (req_op == OP_SOC_START && run) || (req_op == OP_SOC_STOP && !run);
  assign rsp_valid = state == DONE;
  assign rsp_err = rsp_valid && err;
  assign rsp_rdata = (rsp_valid && !err && op == OP_READ) ? rdata : '0;
  assign soc_running = run;
  link_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
    .clk(clk),
    .rst(rst),
    .clr((state == CMD && tx_fire) || (state == RDATA && rx_fire)),
    .en(state == RDATA),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_fire ? (bad_soc ? DONE : CMD) : IDLE;
      CMD:     state_n = !tx_fire ? CMD : op == OP_WRITE ? WDATA : op == OP_READ ? RDATA : DONE;
      WDATA:   state_n = (tx_fire && cnt == 2'd3) ? DONE : WDATA;
      RDATA:   state_n = ((rx_fire && cnt == 2'd3) || (!rx_fire && expired)) ? DONE : RDATA;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= OP_READ;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      cnt <= '0;
      err <= 1'b0;
      run <= 1'b0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      live <= 1'b1;
      if (req_fire) begin
        op <= op_t'(req_op);
        addr <= req_addr;
        wdata <= req_wdata;
        rdata <= '0;
        err <= bad_soc;
      end
      if (state == CMD && tx_fire) begin
        cnt <= '0;
        run <= op == OP_SOC_START ? 1'b1 : op == OP_SOC_STOP ? 1'b0 : run;
      end
      if (state == WDATA && tx_fire) cnt <= cnt + 1'b1;
      if (state == RDATA && rx_fire) begin
        cnt <= cnt + 1'b1;
        rdata <= {rx_data, rdata[31:8]};
      end
      if (state == RDATA && !rx_fire && expired) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_link_host.sv
// tb_sram_link_host: randomized requests and a responder model checked against byte/word-level expectations
module tb_sram_link_host;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = '0;
  logic [4:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic rsp_valid, rsp_err, soc_running;
  logic [31:0] rsp_rdata;
  logic tx_valid, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic rx_valid = 1'b0, rx_ready, rx_drop;
  logic [7:0] rx_data = '0;
  int cyc = 0, n_tests = 0, n_fail = 0;
  bit soc_m = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sram_link_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .soc_running(soc_running),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_drop(rx_drop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // txmode: 0 tx_ready tied 1, 1 random, 2 ten-cycle stall before the third byte; gap<0 picks random response gaps
  task automatic run_req(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd, input int nrx, input int txmode, input int gap);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] rbytes[4];
    logic [7:0] prev_d;
    logic [31:0] exp_rd;
    bit rej, to, done, prev_hold;
    int last, sent, wait_n, stall, k;
    rej = (op == 2'd2 && soc_m) || (op == 2'd3 && !soc_m);
    to = op == 2'd0 && nrx < 4;
    for (int i = 0; i < 4; i++) rbytes[i] = 8'($urandom);
    exp_rd = (op == 2'd0 && !to) ? {rbytes[3], rbytes[2], rbytes[1], rbytes[0]} : 32'h0;
    if (!rej) begin
      if (op == 2'd0) exp_q.push_back(8'h20 | {3'b000, a});
      if (op == 2'd1) begin
        exp_q.push_back({3'b000, a});
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[8*i +: 8]);
      end
      if (op == 2'd2) exp_q.push_back(8'h40);
      if (op == 2'd3) exp_q.push_back(8'h80);
    end
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      tick;
      k++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    last = cyc;
    tick;
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_addr = 5'($urandom);
    req_wdata = $urandom;
    done = 1'b0;
    prev_hold = 1'b0;
    prev_d = '0;
    k = 0;
    sent = 0;
    stall = 0;
    wait_n = gap < 0 ? $urandom_range(0, 5) : gap;
    while (!done && k < 200) begin
      if (rsp_valid) done = 1'b1;
      else begin
        if (prev_hold) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_data", 32'(tx_data), 32'(prev_d));
        end
        tx_ready = txmode == 0 ? 1'b1 : txmode == 1 ? ($urandom_range(0, 3) != 0) : !(got_q.size() == 2 && stall < 10);
        if (!tx_ready) stall++;
        if (tx_valid && tx_ready) begin
          got_q.push_back(tx_data);
          last = cyc;
        end
        prev_hold = tx_valid && !tx_ready;
        prev_d = tx_data;
        rx_valid = 1'b0;
        if (op == 2'd0 && !rej && got_q.size() > 0 && sent < nrx) begin
          if (wait_n > 0) wait_n--;
          else begin
            rx_valid = 1'b1;
            rx_data = rbytes[sent];
          end
        end
        if (rx_valid && rx_ready) begin
          sent++;
          last = cyc;
          wait_n = gap < 0 ? $urandom_range(0, 5) : gap;
        end
        tick;
        k++;
      end
    end
    rx_valid = 1'b0;
    chk("rsp_seen", 32'(done), 32'd1);
    chk("rsp_latency", 32'(cyc - last), to ? 32'(TO + 1) : 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(rej || to));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    if (!rej && op == 2'd2) soc_m = 1'b1;
    if (!rej && op == 2'd3) soc_m = 1'b0;
    chk("soc_running", 32'(soc_running), 32'(soc_m));
    chk("tx_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("tx_byte", i < got_q.size() ? 32'(got_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
    tick;
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k, op, nrx;
    tick;
    tick;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_soc", 32'(soc_running), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd0);
    tick;
    chk("rel_req_ready_next", 32'(req_ready), 32'd1);
    run_req(2'd1, 5'd5, 32'hDEADBEEF, 4, 0, 0);
    run_req(2'd0, 5'h1F, 32'h0, 4, 0, 3);
    run_req(2'd1, 5'd9, 32'hDEADBEEF, 4, 2, 0);
    run_req(2'd3, 5'd0, 32'h0, 4, 0, 0);
    run_req(2'd2, 5'd0, 32'h0, 4, 0, 0);
    run_req(2'd2, 5'd0, 32'h0, 4, 0, 0);
    run_req(2'd3, 5'd0, 32'h0, 4, 0, 0);
    run_req(2'd0, 5'd7, 32'h0, 2, 0, 2);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    #1;
    chk("late_rx_ready", 32'(rx_ready), 32'd1);
    chk("late_rx_drop", 32'(rx_drop), 32'd1);
    tick;
    rx_valid = 1'b0;
    #1;
    chk("late_rx_drop_clear", 32'(rx_drop), 32'd0);
    tick;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      nrx = (op == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 4;
      run_req(2'(op), 5'($urandom), $urandom, nrx, 1, -1);
    end
    if (!soc_m) run_req(2'd2, 5'd0, 32'h0, 4, 0, 0);
    req_op = 2'd1;
    req_addr = 5'd3;
    req_wdata = $urandom;
    req_valid = 1'b1;
    tx_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 20) begin
      if (tx_valid) n++;
      tick;
      k++;
    end
    chk("rst_mid_setup", 32'(n), 32'd3);
    rst = 1'b1;
    tick;
    soc_m = 1'b0;
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_soc", 32'(soc_running), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_mid_rel", 32'(req_ready), 32'd0);
    tick;
    chk("rst_mid_rel_next", 32'(req_ready), 32'd1);
    run_req(2'd3, 5'd0, 32'h0, 4, 0, 0);
    run_req(2'd1, 5'd17, $urandom, 4, 1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
